// File: rtl/la_checkpoint_monitor_if.sv
// la_checkpoint_monitor_if: checkpoint bus, expected-table config and result signals
// master drives checkbits/config/start, slave (the monitor) drives the results.
interface la_checkpoint_monitor_if #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT_W = 24
);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = IW + 1;
   logic [WIDTH-1:0]     checkbits_i;
   logic                 cfg_we_i;
   logic [IW-1:0]        cfg_idx_i;
   logic [WIDTH-1:0]     cfg_data_i;
   logic [SW-1:0]        cfg_len_i;
   logic [TIMEOUT_W-1:0] timeout_i;
   logic                 start_i;
   logic                 busy_o;
   logic                 pass_o;
   logic                 fail_o;
   logic                 timeout_o;
   logic [SW-1:0]        step_o;
   logic [WIDTH-1:0]     last_o;
   modport master (
      output checkbits_i, cfg_we_i, cfg_idx_i, cfg_data_i, cfg_len_i, timeout_i, start_i,
      input  busy_o, pass_o, fail_o, timeout_o, step_o, last_o
   );
   modport slave (
      input  checkbits_i, cfg_we_i, cfg_idx_i, cfg_data_i, cfg_len_i, timeout_i, start_i,
      output busy_o, pass_o, fail_o, timeout_o, step_o, last_o
   );
endinterface

// File: rtl/la_checkpoint_monitor.sv
// la_checkpoint_monitor: synchronise, qualify and sequence-match the firmware checkpoint word.
// Define CHECKMON_STRICT_EN to fail on unexpected values in TRACK; otherwise wait-until semantics.
module la_checkpoint_monitor #(
   parameter int WIDTH         = 16,
   parameter int DEPTH         = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_W     = 24
) (
   input logic wb_clk_i,
   input logic wb_rstn_i,
   la_checkpoint_monitor_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = IW + 1;
   localparam int CW = $clog2(STABLE_CYCLES + 2);
   localparam logic [CW-1:0] CNT_QUAL = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] LEN_MAX  = SW'(DEPTH);
`ifdef CHECKMON_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_TRACK, S_PASS, S_FAIL, S_TIMEOUT} state_t;

   logic [WIDTH-1:0]     sync1, sync2, held;
   logic [CW-1:0]        cnt;
   logic                 qual;
   logic [WIDTH-1:0]     exp_q [DEPTH];
   state_t               state;
   logic [SW-1:0]        len, step, step_n, len_in;
   logic [IW-1:0]        step_i;
   logic [TIMEOUT_W-1:0] tmo, tcnt, tinc;
   logic                 busy, pass, fail, tout;
   logic [WIDTH-1:0]     last;
   logic                 hit, rep, t_hit;

   // held is the synced word one cycle ago; the count saturates one past the qualify point
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         sync1 <= '0;
         sync2 <= '0;
         held  <= '0;
         cnt   <= '0;
      end else begin
         sync1 <= bus.checkbits_i;
         sync2 <= sync1;
         held  <= sync2;
         cnt   <= (sync2 != held) ? CW'(1) : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
   end

   assign qual   = cnt == CNT_QUAL;
   assign step_i = step[IW-1:0];
   assign step_n = step + 1'b1;
   assign len_in = (bus.cfg_len_i > LEN_MAX) ? LEN_MAX : bus.cfg_len_i;
   assign hit    = qual && held == exp_q[step_i];
   assign rep    = held == exp_q[step_i - 1'b1];
   assign tinc   = (&tcnt) ? tcnt : tcnt + 1'b1;
   // >= so a timeout deferred by a same-cycle match still fires next cycle
   assign t_hit  = tmo != '0 && tinc >= tmo;

   always_ff @(posedge wb_clk_i) begin
      if (bus.cfg_we_i && !busy && !bus.start_i) exp_q[bus.cfg_idx_i] <= bus.cfg_data_i;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state <= S_IDLE;
         len   <= '0;
         step  <= '0;
         tmo   <= '0;
         tcnt  <= '0;
         busy  <= 1'b0;
         pass  <= 1'b0;
         fail  <= 1'b0;
         tout  <= 1'b0;
         last  <= '0;
      end else begin
         if (qual) last <= held;
         if (bus.start_i) begin
            len   <= len_in;
            tmo   <= bus.timeout_i;
            tcnt  <= '0;
            step  <= '0;
            fail  <= 1'b0;
            tout  <= 1'b0;
            pass  <= len_in == '0;
            busy  <= len_in != '0;
            state <= (len_in == '0) ? S_PASS : S_ARMED;
         end else if (busy) begin
            tcnt <= tinc;
            if (hit) begin
               step  <= step_n;
               pass  <= step_n == len;
               busy  <= step_n != len;
               state <= (step_n == len) ? S_PASS : S_TRACK;
            end else if (STRICT && qual && state == S_TRACK && !rep) begin
               fail  <= 1'b1;
               busy  <= 1'b0;
               state <= S_FAIL;
            end else if (t_hit) begin
               tout  <= 1'b1;
               busy  <= 1'b0;
               state <= S_TIMEOUT;
            end
         end
      end
   end

   assign bus.busy_o    = busy;
   assign bus.pass_o    = pass;
   assign bus.fail_o    = fail;
   assign bus.timeout_o = tout;
   assign bus.step_o    = step;
   assign bus.last_o    = last;
endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// tb_la_checkpoint_monitor: directed checkpoint sequences against a sample-history model.
// Works for both builds; CHECKMON_STRICT_EN selects the strict expectations.
module tb_la_checkpoint_monitor;
   localparam int S = 4;
`ifdef CHECKMON_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;

   la_checkpoint_monitor_if #(.WIDTH(16), .DEPTH(4), .TIMEOUT_W(24)) bus ();
   la_checkpoint_monitor #(.WIDTH(16), .DEPTH(4), .STABLE_CYCLES(S), .TIMEOUT_W(24)) dut (
      .wb_clk_i(clk), .wb_rstn_i(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Model: a value qualifies when it was sampled on S consecutive edges (after a different
   // sample) ending 3 edges ago; sequence rules are then applied to those events.
   int          h[$];
   logic [15:0] em [4];
   int          m_len = 0, m_step = 0, m_bc = 0, m_tmo = 0, mv = 0;
   bit          m_busy = 0, m_pass = 0, m_fail = 0, m_tout = 0, mq = 0;
   logic [15:0] m_last = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h = {};
         repeat (S + 4) h.push_front(-1);
         m_len = 0; m_step = 0; m_bc = 0; m_tmo = 0;
         m_busy = 0; m_pass = 0; m_fail = 0; m_tout = 0; m_last = '0;
      end else begin
         h.push_front(int'(bus.checkbits_i));
         void'(h.pop_back());
         mq = h[3] != -1 && h[S+3] != h[S+2];
         for (int k = 3; k < S + 2; k++) if (h[k] != h[k+1]) mq = 0;
         mv = h[3];
         if (bus.cfg_we_i && !m_busy && !bus.start_i) em[bus.cfg_idx_i] = bus.cfg_data_i;
         if (mq) m_last = mv[15:0];
         if (bus.start_i) begin
            m_len  = (bus.cfg_len_i > 4) ? 4 : int'(bus.cfg_len_i);
            m_tmo  = int'(bus.timeout_i);
            m_step = 0; m_bc = 0; m_fail = 0; m_tout = 0;
            m_pass = m_len == 0;
            m_busy = m_len != 0;
         end else if (m_busy) begin
            m_bc++;
            if (mq && mv == int'(em[m_step])) begin
               m_step++;
               if (m_step == m_len) begin m_pass = 1; m_busy = 0; end
            end else if (STRICT && mq && m_step > 0 && mv != int'(em[m_step-1])) begin
               m_fail = 1; m_busy = 0;
            end else if (m_tmo != 0 && m_bc >= m_tmo) begin
               m_tout = 1; m_busy = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("m_busy", 32'(bus.busy_o), 32'(m_busy));
      chk("m_pass", 32'(bus.pass_o), 32'(m_pass));
      chk("m_fail", 32'(bus.fail_o), 32'(m_fail));
      chk("m_timeout", 32'(bus.timeout_o), 32'(m_tout));
      chk("m_step", 32'(bus.step_o), 32'(m_step));
      chk("m_last", 32'(bus.last_o), 32'(m_last));
   end

   task automatic hold(input logic [15:0] v, input int n);
      bus.checkbits_i = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] idx, input logic [15:0] d);
      bus.cfg_we_i = 1'b1; bus.cfg_idx_i = idx; bus.cfg_data_i = d;
      @(negedge clk);
      bus.cfg_we_i = 1'b0;
   endtask

   task automatic go(input logic [2:0] len, input logic [23:0] tmo);
      bus.start_i = 1'b1; bus.cfg_len_i = len; bus.timeout_i = tmo;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic flags(input string t, input bit b, input bit p, input bit f, input bit to, input int st);
      chk({t, "_busy"}, 32'(bus.busy_o), 32'(b));
      chk({t, "_pass"}, 32'(bus.pass_o), 32'(p));
      chk({t, "_fail"}, 32'(bus.fail_o), 32'(f));
      chk({t, "_timeout"}, 32'(bus.timeout_o), 32'(to));
      chk({t, "_step"}, 32'(bus.step_o), 32'(st));
   endtask

   initial begin
      int k;
      bus.checkbits_i = '0; bus.cfg_we_i = 0; bus.cfg_idx_i = '0; bus.cfg_data_i = '0;
      bus.cfg_len_i = '0; bus.timeout_i = '0; bus.start_i = 0;
      repeat (3) @(negedge clk);
      flags("reset", 0, 0, 0, 0, 0);
      chk("reset_last", 32'(bus.last_o), 32'h0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      wr(0, 16'hAB40); wr(1, 16'hAB41); wr(2, 16'hAB51);

      // basic sequence, plus a write while busy that must be ignored
      go(3, 0);
      hold(16'hAB40, 20);
      flags("t1a", 1, 0, 0, 0, 1);
      chk("t1a_last", 32'(bus.last_o), 32'hAB40);
      wr(2, 16'h1111);
      hold(16'hAB41, 20);
      flags("t1b", 1, 0, 0, 0, 2);
      bus.checkbits_i = 16'hAB51;
      k = 0;
      while (!bus.pass_o && k < 50) begin @(negedge clk); k++; end
      chk("t1_latency", 32'(k - 1), 32'(2 + S));
      repeat (10) @(negedge clk);
      flags("t1c", 0, 1, 0, 0, 3);
      chk("t1c_last", 32'(bus.last_o), 32'hAB51);

      // boot noise and a repeat of the current checkpoint
      hold(16'h0000, 10);
      go(3, 0);
      hold(16'h0000, 20); hold(16'h1234, 20); hold(16'hAB40, 20);
      hold(16'h5555, 2);  hold(16'hAB40, 20); hold(16'hAB41, 20); hold(16'hAB51, 20);
      flags("t2", 0, 1, 0, 0, 3);

      // unexpected value in TRACK
      hold(16'h0000, 10);
      go(3, 0);
      hold(16'hAB40, 20); hold(16'hDEAD, 20);
`ifdef CHECKMON_STRICT_EN
      flags("t3", 0, 0, 1, 0, 1);
`else
      flags("t3", 1, 0, 0, 0, 1);
      hold(16'hAB41, 20); hold(16'hAB51, 20);
      flags("t3b", 0, 1, 0, 0, 3);
`endif

      // timeout after 100 busy cycles; len 7 clamps to 4
      hold(16'h0000, 10);
      go(7, 100);
      bus.checkbits_i = 16'hAB40;
      k = 0;
      while (bus.busy_o && k < 300) begin k++; @(negedge clk); end
      chk("t4_busy_cycles", 32'(k), 32'd100);
      flags("t4", 0, 0, 0, 1, 1);

      // glitch shorter than the stability window
      hold(16'h0000, 10);
      go(3, 0);
      hold(16'hAB40, 20); hold(16'hAB41, S - 1);
      hold(16'hAB51, 5);
      chk("t5_last_glitch", 32'(bus.last_o), 32'hAB40);
      hold(16'hAB51, 15);
      chk("t5_last", 32'(bus.last_o), 32'hAB51);
`ifdef CHECKMON_STRICT_EN
      flags("t5", 0, 0, 1, 0, 1);
`else
      flags("t5", 1, 0, 0, 0, 1);
`endif

      // len 0 with a simultaneous table write that must be ignored
      hold(16'h0000, 10);
      bus.cfg_we_i = 1; bus.cfg_idx_i = 0; bus.cfg_data_i = 16'hFFFF;
      go(0, 0);
      bus.cfg_we_i = 0;
      flags("t6", 0, 1, 0, 0, 0);

      // reset in TRACK
      hold(16'h0000, 10);
      go(3, 0);
      hold(16'hAB40, 20);
      flags("t7a", 1, 0, 0, 0, 1);
      rst_n = 1'b0;
      #1;
      flags("t7", 0, 0, 0, 0, 0);
      chk("t7_last", 32'(bus.last_o), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // rerun on the retained table
      hold(16'h0000, 10);
      go(3, 0);
      hold(16'hAB40, 20); hold(16'hAB41, 20); hold(16'hAB51, 20);
      flags("t8", 0, 1, 0, 0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
